// File: rtl/modred_serial_if.sv
// Handshake and operand/result bundle for modred_serial.
// The master modport drives requests; the slave modport is the reducer side.
interface modred_serial_if #(
    parameter int XW = 64,
    parameter int MW = 32
);
    localparam int KW = $clog2(MW + 1);

    logic          start;
    logic          mode;
    logic [XW-1:0] x;
    logic [MW-1:0] m;
    logic [KW-1:0] m_bl;
    logic          ready;
    logic          busy;
    logic          valid;
    logic          err;
    logic [MW-1:0] result;

    modport master (
        output start, mode, x, m, m_bl,
        input  ready, busy, valid, err, result
    );

    modport slave (
        input  start, mode, x, m, m_bl,
        output ready, busy, valid, err, result
    );
endinterface

// File: rtl/modred_serial.sv
// Serial modular reducer: result = x mod m, BPC dividend bits per cycle.
// Optional Mersenne folding datapath (mod 2^k-1) enabled by MODRED_MERSENNE_FAST_EN.
module modred_serial #(
    parameter int XW  = 64,
    parameter int MW  = 32,
    parameter int BPC = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    modred_serial_if.slave  bus
);
    localparam int N  = XW / BPC;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam int KW = $clog2(MW + 1);

    if (XW % BPC != 0) begin : g_bad_bpc
        $error("modred_serial: XW must be a multiple of BPC");
    end
    if (MW >= XW) begin : g_bad_mw
        $error("modred_serial: MW must be smaller than XW");
    end

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state, state_nx;
    logic          accept, step, finish, finish_err;
    logic [MW-1:0] finish_val;

    logic [XW-1:0] x_sh, x_nx;
    logic [MW:0]   rem, rem_nx;
    logic [MW-1:0] m_q;
    logic [CW-1:0] cnt;
    logic          err_q;
    logic [MW-1:0] result_q;

    logic          use_fold, fold_bad, fold_done;
    logic [MW-1:0] fold_res;

    // Restoring shift-subtract; rem stays below m so its top bit is clear before each shift.
    always_comb begin
        rem_nx = rem;
        x_nx   = x_sh;
        for (int i = 0; i < BPC; i++) begin
            rem_nx = {rem_nx[MW-1:0], x_nx[XW-1]};
            x_nx   = x_nx << 1;
            if (rem_nx >= {1'b0, m_q}) begin
                rem_nx = rem_nx - {1'b0, m_q};
            end
        end
    end

`ifdef MODRED_MERSENNE_FAST_EN
    logic          mode_q;
    logic [KW-1:0] k_q;
    logic [XW:0]   acc, mask, hi, fold_sum;

    always_comb begin
        mask     = ((XW+1)'(1) << k_q) - (XW+1)'(1);
        hi       = acc >> k_q;
        fold_sum = (acc & mask) + hi;
    end

    assign use_fold  = mode_q;
    assign fold_bad  = (k_q < KW'(2)) || (k_q > KW'(MW));
    assign fold_done = (hi == '0);
    // 2^k-1 is congruent to zero, the only fixed point of the fold that is not reduced.
    assign fold_res  = (acc == mask) ? '0 : acc[MW-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q <= 1'b0;
            k_q    <= '0;
            acc    <= '0;
        end else if (accept) begin
            mode_q <= bus.mode;
            k_q    <= bus.m_bl;
            acc    <= {1'b0, bus.x};
        end else if (step && mode_q) begin
            acc <= fold_sum;
        end
    end
`else
    logic unused_cfg;
    assign unused_cfg = ^{bus.mode, bus.m_bl};
    assign use_fold   = 1'b0;
    assign fold_bad   = 1'b0;
    assign fold_done  = 1'b0;
    assign fold_res   = '0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        accept     = 1'b0;
        step       = 1'b0;
        finish     = 1'b0;
        finish_err = 1'b0;
        finish_val = '0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    accept   = 1'b1;
                    state_nx = RUN;
                end
            end
            RUN: begin
                if (use_fold) begin
                    if (fold_bad) begin
                        finish     = 1'b1;
                        finish_err = 1'b1;
                    end else if (fold_done) begin
                        finish     = 1'b1;
                        finish_val = fold_res;
                    end else begin
                        step = 1'b1;
                    end
                end else if (m_q == '0) begin
                    finish     = 1'b1;
                    finish_err = 1'b1;
                end else begin
                    step = 1'b1;
                    if (cnt == CW'(N - 1)) begin
                        finish     = 1'b1;
                        finish_val = rem_nx[MW-1:0];
                    end
                end
                if (finish) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                if (bus.start) begin
                    accept   = 1'b1;
                    state_nx = RUN;
                end else begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_sh <= '0;
            rem  <= '0;
            m_q  <= '0;
            cnt  <= '0;
        end else if (accept) begin
            x_sh <= bus.x;
            rem  <= '0;
            m_q  <= bus.m;
            cnt  <= '0;
        end else if (step && !use_fold) begin
            x_sh <= x_nx;
            rem  <= rem_nx;
            cnt  <= cnt + 1'b1;
        end
    end

    // Result is held through the next run; only err is cleared when a new op is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q    <= 1'b0;
            result_q <= '0;
        end else if (accept) begin
            err_q <= 1'b0;
        end else if (finish) begin
            err_q    <= finish_err;
            result_q <= finish_val;
        end
    end

    assign bus.ready  = (state == IDLE) || (state == DONE);
    assign bus.busy   = (state == RUN);
    assign bus.valid  = (state == DONE);
    assign bus.err    = err_q;
    assign bus.result = result_q;
endmodule

// File: tb/tb_modred_serial.sv
// Directed self-checking bench for modred_serial (BPC=1 and BPC=4 instances).
// Mersenne vectors are exercised only when MODRED_MERSENNE_FAST_EN is defined.
module tb_modred_serial;
    logic clk;
    logic rst_n;
    int   vectors;
    int   miscompares;

    modred_serial_if #(.XW(64), .MW(32)) bus1 ();
    modred_serial_if #(.XW(64), .MW(32)) bus4 ();

    modred_serial #(.XW(64), .MW(32), .BPC(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
    modred_serial #(.XW(64), .MW(32), .BPC(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic apply_stimulus(input bit sel, input logic st, input logic md,
                                  input logic [63:0] x, input logic [31:0] m, input logic [5:0] k);
        if (sel) begin
            bus4.start = st; bus4.mode = md; bus4.x = x; bus4.m = m; bus4.m_bl = k;
        end else begin
            bus1.start = st; bus1.mode = md; bus1.x = x; bus1.m = m; bus1.m_bl = k;
        end
    endtask

    task automatic set_start(input bit sel, input logic v);
        if (sel) bus4.start = v;
        else     bus1.start = v;
    endtask

    function automatic logic dut_valid(input bit sel);
        return sel ? bus4.valid : bus1.valid;
    endfunction

    // Counts edges after the acceptance edge until valid is seen; lat stays 0 on timeout.
    task automatic wait_result(input bit sel, output int lat, output logic [31:0] res, output logic er);
        lat = 0; res = '0; er = 1'b0;
        for (int c = 1; c <= 200; c++) begin
            @(posedge clk); #1;
            if (dut_valid(sel)) begin
                lat = c;
                res = sel ? bus4.result : bus1.result;
                er  = sel ? bus4.err : bus1.err;
                return;
            end
        end
    endtask

    task automatic run_op(input bit sel, input logic md, input logic [63:0] x, input logic [31:0] m,
                          input logic [5:0] k, output int lat, output logic [31:0] res, output logic er);
        @(negedge clk);
        apply_stimulus(sel, 1'b1, md, x, m, k);
        @(posedge clk); #1;
        set_start(sel, 1'b0);
        wait_result(sel, lat, res, er);
    endtask

    initial begin
        int          lat;
        logic [31:0] res;
        logic        er;
        logic [63:0] rx;
        int          seen;

        vectors = 0;
        miscompares = 0;
        rst_n = 1'b0;
        apply_stimulus(1'b0, 1'b0, 1'b0, 64'h0, 32'h0, 6'd0);
        apply_stimulus(1'b1, 1'b0, 1'b0, 64'h0, 32'h0, 6'd0);
        #12;
        check_output("reset_ready", bus1.ready, 1);
        check_output("reset_busy", bus1.busy, 0);
        check_output("reset_valid", bus1.valid, 0);
        check_output("reset_err", bus1.err, 0);
        check_output("reset_result", bus1.result, 0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op(1'b0, 1'b0, 64'h1, 32'h7FFFFF, 6'd0, lat, res, er);
        check_output("gen_x1_result", res, 32'h1);
        check_output("gen_x1_latency", lat, 64);
        check_output("gen_x1_err", er, 0);
        @(posedge clk); #1;
        check_output("gen_x1_valid_pulse", bus1.valid, 0);

        run_op(1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 32'h7FFFFF, 6'd0, lat, res, er);
        check_output("gen_ones_result", res, 32'h3FFFF);
        check_output("gen_ones_latency", lat, 64);

        run_op(1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 32'h7FFFFF, 6'd0, lat, res, er);
        check_output("bpc4_ones_result", res, 32'h3FFFF);
        check_output("bpc4_ones_latency", lat, 16);

        run_op(1'b0, 1'b0, 64'h1234, 32'h0, 6'd0, lat, res, er);
        check_output("gen_m0_err", er, 1);
        check_output("gen_m0_result", res, 0);
        check_output("gen_m0_latency", lat, 1);

        // Start accepted in the DONE cycle of the error op; err must clear on acceptance.
        @(negedge clk);
        apply_stimulus(1'b0, 1'b1, 1'b0, 64'h1234_5678_9ABC_DEF0, 32'h10000, 6'd0);
        @(posedge clk); #1;
        check_output("accept_err_clear", bus1.err, 0);
        check_output("accept_busy", bus1.busy, 1);
        set_start(1'b0, 1'b0);
        wait_result(1'b0, lat, res, er);
        check_output("pow2_result", res, 32'hDEF0);
        check_output("pow2_latency", lat, 64);
        check_output("pow2_err", er, 0);

        // Immediate restart from DONE.
        run_op(1'b0, 1'b0, 64'h5, 32'h7FFFFF, 6'd0, lat, res, er);
        check_output("b2b_result", res, 32'h5);
        check_output("b2b_latency", lat, 64);

`ifdef MODRED_MERSENNE_FAST_EN
        run_op(1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 32'h0, 6'd23, lat, res, er);
        check_output("mers_ones_result", res, 32'h3FFFF);
        check_output("mers_ones_latency", lat, 4);
        check_output("mers_ones_err", er, 0);
        run_op(1'b0, 1'b1, 64'h7FFFFF, 32'h0, 6'd23, lat, res, er);
        check_output("mers_eqm_result", res, 0);
        check_output("mers_eqm_latency", lat, 1);
        run_op(1'b0, 1'b1, 64'h55, 32'h0, 6'd1, lat, res, er);
        check_output("mers_k1_err", er, 1);
        check_output("mers_k1_result", res, 0);
        check_output("mers_k1_latency", lat, 1);
        run_op(1'b0, 1'b1, 64'h800000, 32'h0, 6'd23, lat, res, er);
        check_output("mers_fold1_result", res, 32'h1);
        check_output("mers_fold1_latency", lat, 2);
        check_output("mers_fold1_err", er, 0);
`else
        run_op(1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 32'h7FFFFF, 6'd1, lat, res, er);
        check_output("mode_ignored_result", res, 32'h3FFFF);
        check_output("mode_ignored_latency", lat, 64);
        check_output("mode_ignored_err", er, 0);
`endif

        // start_i held high and inputs changed during RUN must not disturb the op.
        @(negedge clk);
        apply_stimulus(1'b0, 1'b1, 1'b0, 64'h1, 32'h7FFFFF, 6'd0);
        @(posedge clk); #1;
        apply_stimulus(1'b0, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 32'h0, 6'd0);
        repeat (5) begin
            @(posedge clk); #1;
        end
        set_start(1'b0, 1'b0);
        wait_result(1'b0, lat, res, er);
        check_output("hold_result", res, 32'h1);
        check_output("hold_latency", lat, 59);
        check_output("hold_err", er, 0);

        for (int i = 0; i < 100; i++) begin
            rx = {$urandom, $urandom};
            run_op(1'b1, 1'b0, rx, 32'h80000001, 6'd0, lat, res, er);
            check_output("rand_result", res, rx % 64'h80000001);
        end

        // Asynchronous reset ten edges into a run.
        @(negedge clk);
        apply_stimulus(1'b0, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 32'h7FFFFF, 6'd0);
        @(posedge clk); #1;
        set_start(1'b0, 1'b0);
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_output("midrst_ready", bus1.ready, 1);
        check_output("midrst_busy", bus1.busy, 0);
        check_output("midrst_valid", bus1.valid, 0);
        check_output("midrst_err", bus1.err, 0);
        check_output("midrst_result", bus1.result, 0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (70) begin
            @(posedge clk); #1;
            if (bus1.valid) seen++;
        end
        check_output("midrst_no_valid", seen, 0);
        run_op(1'b0, 1'b0, 64'h1, 32'h7FFFFF, 6'd0, lat, res, er);
        check_output("post_rst_result", res, 32'h1);
        check_output("post_rst_latency", lat, 64);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/modred_serial.md
# modred_serial

Parametrised serial modular reducer computing result = x mod m for an XW-bit operand and an MW-bit modulus. It succeeds the single-mode shift-add reducer: widths and bits-per-cycle are generics, it exposes a ready/busy/valid/err handshake, and an optional Mersenne folding mode reduces modulo 2^k−1 in data-dependent, much shorter time. It sits in the arithmetic datapath behind multipliers, reducing double-width products.

## Interface
- XW, 64, operand width; XW % BPC == 0 (elaboration error otherwise)
- MW, 32, modulus/result width; MW < XW
- BPC, 1, dividend bits consumed per cycle in generic mode; N = XW/BPC
- clk_i  in  1  clock, rising edge active
- rst_ni  in  1  asynchronous active-low reset
- start_i  in  1  start request, sampled only when ready_o=1
- mode_i  in  1  0 = generic, 1 = Mersenne (see Configuration)
- x_i  in  XW  operand, latched at accepted start
- m_i  in  MW  modulus (generic mode), latched at accepted start
- m_bl_i  in  $clog2(MW+1)  k, modulus bit length (Mersenne mode: m = 2^k−1), latched
- ready_o  out  1  can accept start (state IDLE or DONE)
- busy_o  out  1  state RUN
- valid_o  out  1  one-cycle result strobe (state DONE)
- err_o  out  1  error qualifier, meaningful only with valid_o
- result_o  out  MW  remainder; held from DONE until next accepted start

## Operation
- States: IDLE, RUN, DONE. Reset → IDLE; all outputs 0 except ready_o=1.
- Accepted start (start_i & ready_o at edge): latch x_i, m_i, m_bl_i, mode_i; clear err; → RUN. start_i with ready_o=0 ignored.
- Generic: r (MW+1 bits) = 0; each RUN edge, BPC times MSB-first: r = (r<<1)|next x bit; if r ≥ m then r −= m. After N edges → DONE, result_o = r[MW−1:0].
- Generic, m_i == 0: RUN performs no iteration; first RUN edge → DONE, err_o=1, result_o=0.
- Mersenne: acc (XW+1 bits) = x. Each RUN edge: if acc>>k ≠ 0, acc = acc[k−1:0] + (acc>>k); else → DONE, result_o = (acc == 2^k−1) ? 0 : acc. m_i ignored.
- Mersenne, k < 2 or k > MW: first RUN edge → DONE, err_o=1, result_o=0.
- DONE: valid_o=1 for one cycle; next edge → RUN if start_i else IDLE.
- Result always < m for valid, non-error operations.

## Timing
- t0 = edge accepting start. busy_o=1 from t0 until DONE entered.
- Generic: valid_o rises at edge t0+N, falls at t0+N+1. Latency N+1 edges incl. acceptance; back-to-back throughput one op per N+1 cycles (start accepted in DONE).
- Mersenne: F = folds needed (0 if x < 2^k); valid_o rises at t0+F+1; F ≤ ceil(XW/k)+1.
- Error cases: valid_o rises at t0+1.
- result_o, err_o change only on the DONE-entry edge or an accepted start (err_o cleared) / reset.
- Reset mid-RUN: immediate abort, outputs to reset values, no valid_o.
- Input changes after acceptance have no effect.

## Configuration
- MODRED_MERSENNE_FAST_EN defined: fold datapath compiled in; mode_i=1 selects Mersenne.
- Undefined: fold datapath absent; mode_i ignored, every operation uses the generic path (m_bl_i unused).

## Test plan
- Generic, m=0x7FFFFF, x=0x1, BPC=1 → result 0x000001, valid_o single pulse at t0+64, err_o=0.
- Generic, m=0x7FFFFF, x=0xFFFFFFFFFFFFFFFF → result 0x03FFFF at t0+64; repeat BPC=4 → same result at t0+16.
- Mersenne (macro on), k=23, x=0xFFFFFFFFFFFFFFFF → result 0x03FFFF, valid at t0+4 (3 folds); x=0x7FFFFF → result 0, valid at t0+1.
- Errors: generic m=0 → err_o=1, result 0 at t0+1; Mersenne k=1 → err_o=1 at t0+1; next valid op clears err_o.
- Handshake: start_i held during RUN ignored; start in DONE cycle accepted, second result correct; 100 random x with m=0x80000001 vs x % m.
- Reset asserted mid-RUN (t0+10) → outputs zero, ready_o=1, no valid_o; subsequent op correct.
